// File: rtl/if_fetch_stage_if.sv
// Fetch-stage bus: redirect/stall controls, instruction-memory port and IF/ID payload.
// master = fetch stage, slave = surrounding pipeline and instruction memory.
interface if_fetch_stage_if;
  logic        stall;
  logic        branch_en;
  logic [31:0] branch_target;
  logic        jump_en;
  logic [31:0] jump_target;
  logic [31:0] im_adress;
  logic [31:0] im_instruction;
  logic [31:0] ifid_instr;
  logic [31:0] ifid_pc;
  logic [31:0] ifid_pc_plus4;
  logic        ifid_valid;
  logic        fetch_fault;

  modport master (
    input  stall, branch_en, branch_target, jump_en, jump_target, im_instruction,
    output im_adress, ifid_instr, ifid_pc, ifid_pc_plus4, ifid_valid, fetch_fault
  );

  modport slave (
    output stall, branch_en, branch_target, jump_en, jump_target, im_instruction,
    input  im_adress, ifid_instr, ifid_pc, ifid_pc_plus4, ifid_valid, fetch_fault
  );
endinterface

// File: rtl/if_fetch_stage.sv
// MIPS instruction-fetch stage: owns the PC, fetches from instruction memory, fills IF/ID.
// Optional misaligned-fetch trap enabled by defining IF_MISALIGN_TRAP_EN.
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int unsigned PC_STEP     = 4,
  parameter logic [31:0] NOP_WORD    = 32'h0000_0000
`ifdef IF_MISALIGN_TRAP_EN
  ,
  parameter logic [31:0] TRAP_VECTOR = 32'h0000_0080
`endif
) (
  input logic             clk,
  input logic             rst,
  if_fetch_stage_if.master bus
);

  typedef enum logic {RUN, REFILL} state_e;

  state_e      state_q;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] ifpc_q, ifpc_d;
  logic [31:0] ifpc4_q, ifpc4_d;
  logic        valid_q, valid_d;
  logic        fault_q, fault_d;
  logic        redirect;
  logic [31:0] pc_plus;

  assign pc_plus = pc_q + 32'(PC_STEP);

  // Next-PC / IF/ID selection: jump > branch > (trap) > stall > sequential advance.
  always_comb begin
    pc_d     = pc_q;
    instr_d  = instr_q;
    ifpc_d   = ifpc_q;
    ifpc4_d  = ifpc4_q;
    valid_d  = valid_q;
    fault_d  = 1'b0;
    redirect = 1'b0;
    if (bus.jump_en) begin
      pc_d     = bus.jump_target;
      instr_d  = NOP_WORD;
      valid_d  = 1'b0;
      redirect = 1'b1;
    end else if (bus.branch_en) begin
      pc_d     = bus.branch_target;
      instr_d  = NOP_WORD;
      valid_d  = 1'b0;
      redirect = 1'b1;
`ifdef IF_MISALIGN_TRAP_EN
    end else if (pc_q[1:0] != 2'b00) begin
      pc_d     = TRAP_VECTOR;
      instr_d  = NOP_WORD;
      valid_d  = 1'b0;
      fault_d  = 1'b1;
      redirect = 1'b1;
`endif
    end else if (!bus.stall) begin
      pc_d    = pc_plus;
      instr_d = bus.im_instruction;
      ifpc_d  = pc_q;
      ifpc4_d = pc_plus;
      valid_d = 1'b1;
    end
  end

  // Pipeline registers and the RUN/REFILL tracker.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      pc_q    <= RESET_PC;
      instr_q <= NOP_WORD;
      ifpc_q  <= 32'h0;
      ifpc4_q <= 32'h0;
      valid_q <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state_q <= redirect ? REFILL : RUN;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      ifpc_q  <= ifpc_d;
      ifpc4_q <= ifpc4_d;
      valid_q <= valid_d;
      fault_q <= fault_d;
    end
  end

  // The cycle after any redirect always presents a bubble on IF/ID.
  always_comb begin
    if (!rst && state_q == REFILL) begin
      assert (!valid_q);
    end
  end

  assign bus.im_adress     = pc_q;
  assign bus.ifid_instr    = instr_q;
  assign bus.ifid_pc       = ifpc_q;
  assign bus.ifid_pc_plus4 = ifpc4_q;
  assign bus.ifid_valid    = valid_q;
`ifdef IF_MISALIGN_TRAP_EN
  assign bus.fetch_fault   = fault_q;
`else
  assign bus.fetch_fault   = 1'b0;
  logic unused_fault;
  assign unused_fault = fault_q ^ fault_d;
`endif

endmodule

// File: tb/tb_if_fetch_stage.sv
// Vector-table bench for if_fetch_stage with a queue scoreboard of post-edge expectations.
module tb_if_fetch_stage;

`ifdef IF_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  typedef struct {
    logic [31:0] adr;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc4;
    logic        v;
    logic        f;
  } exp_t;

  typedef struct {
    logic        rst;
    logic        stall;
    logic        br;
    logic [31:0] bt;
    logic        j;
    logic [31:0] jt;
    exp_t        e;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t sb[$];
  vec_t vecs[25];

  if_fetch_stage_if bus();

  if_fetch_stage dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Big-endian memory whose byte at address a holds a[7:0].
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [31:0] a1, a2, a3;
    a1 = a + 32'd1;
    a2 = a + 32'd2;
    a3 = a + 32'd3;
    return {a[7:0], a1[7:0], a2[7:0], a3[7:0]};
  endfunction

  always_comb bus.im_instruction = mem_word(bus.im_adress);

  function automatic exp_t mk_e(input logic [31:0] adr, input logic [31:0] instr,
                                input logic [31:0] pc, input logic [31:0] pc4,
                                input logic v, input logic f);
    exp_t e;
    e.adr = adr; e.instr = instr; e.pc = pc; e.pc4 = pc4; e.v = v; e.f = f;
    return e;
  endfunction

  function automatic vec_t mk(input logic r, input logic s, input logic b, input logic [31:0] bt,
                              input logic j, input logic [31:0] jt, input exp_t e);
    vec_t x;
    x.rst = r; x.stall = s; x.br = b; x.bt = bt; x.j = j; x.jt = jt; x.e = e;
    return x;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_tests++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp_v);
    end
  endtask

  task automatic compare_pop(input int idx);
    exp_t e;
    if (sb.size() == 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL scoreboard_empty at step %0d: got 0 entries, expected 1", idx);
      return;
    end
    e = sb.pop_front();
    chk($sformatf("im_adress[%0d]", idx),     bus.im_adress,            e.adr);
    chk($sformatf("ifid_instr[%0d]", idx),    bus.ifid_instr,           e.instr);
    chk($sformatf("ifid_pc[%0d]", idx),       bus.ifid_pc,              e.pc);
    chk($sformatf("ifid_pc_plus4[%0d]", idx), bus.ifid_pc_plus4,        e.pc4);
    chk($sformatf("ifid_valid[%0d]", idx),    32'(bus.ifid_valid),      32'(e.v));
    chk($sformatf("fetch_fault[%0d]", idx),   32'(bus.fetch_fault),     32'(e.f));
  endtask

  task automatic apply(input vec_t x, input int idx);
    @(negedge clk);
    rst               = x.rst;
    bus.stall         = x.stall;
    bus.branch_en     = x.br;
    bus.branch_target = x.bt;
    bus.jump_en       = x.j;
    bus.jump_target   = x.jt;
    sb.push_back(x.e);
    @(posedge clk);
    #1;
    compare_pop(idx);
  endtask

  initial begin
    logic [31:0] hp, hp4, pc;
    bus.stall = 1'b0; bus.branch_en = 1'b0; bus.branch_target = '0;
    bus.jump_en = 1'b0; bus.jump_target = '0;

    hp  = TRAP ? 32'h80 : 32'h0A;
    hp4 = TRAP ? 32'h84 : 32'h0E;

    vecs[0]  = mk(1, 0, 0, 0, 0, 0, mk_e(32'h0, 32'h0, 32'h0, 32'h0, 0, 0));
    vecs[1]  = mk(1, 1, 1, 32'h44, 0, 0, mk_e(32'h0, 32'h0, 32'h0, 32'h0, 0, 0));
    vecs[2]  = mk(0, 0, 0, 0, 0, 0, mk_e(32'h4, 32'h00010203, 32'h0, 32'h4, 1, 0));
    vecs[3]  = mk(0, 0, 0, 0, 0, 0, mk_e(32'h8, 32'h04050607, 32'h4, 32'h8, 1, 0));
    vecs[4]  = mk(0, 1, 0, 0, 0, 0, mk_e(32'h8, 32'h04050607, 32'h4, 32'h8, 1, 0));
    vecs[5]  = mk(0, 1, 0, 0, 0, 0, mk_e(32'h8, 32'h04050607, 32'h4, 32'h8, 1, 0));
    vecs[6]  = mk(0, 1, 0, 0, 0, 0, mk_e(32'h8, 32'h04050607, 32'h4, 32'h8, 1, 0));
    vecs[7]  = mk(0, 0, 0, 0, 0, 0, mk_e(32'hC, 32'h08090A0B, 32'h8, 32'hC, 1, 0));
    vecs[8]  = mk(0, 1, 1, 32'h14, 0, 0, mk_e(32'h14, 32'h0, 32'h8, 32'hC, 0, 0));
    vecs[9]  = mk(0, 0, 0, 0, 0, 0, mk_e(32'h18, 32'h14151617, 32'h14, 32'h18, 1, 0));
    vecs[10] = mk(0, 0, 1, 32'h18, 1, 32'h0C, mk_e(32'hC, 32'h0, 32'h14, 32'h18, 0, 0));
    vecs[11] = mk(0, 0, 0, 0, 0, 0, mk_e(32'h10, 32'h0C0D0E0F, 32'hC, 32'h10, 1, 0));
    vecs[12] = mk(1, 1, 0, 0, 1, 32'h40, mk_e(32'h0, 32'h0, 32'h0, 32'h0, 0, 0));
    vecs[13] = mk(0, 1, 0, 0, 0, 0, mk_e(32'h0, 32'h0, 32'h0, 32'h0, 0, 0));
    vecs[14] = mk(0, 0, 0, 0, 0, 0, mk_e(32'h4, 32'h00010203, 32'h0, 32'h4, 1, 0));
    vecs[15] = mk(0, 0, 0, 0, 1, 32'hFFFF_FFFC, mk_e(32'hFFFF_FFFC, 32'h0, 32'h0, 32'h4, 0, 0));
    vecs[16] = mk(0, 0, 0, 0, 0, 0, mk_e(32'h0, 32'hFCFDFEFF, 32'hFFFF_FFFC, 32'h0, 1, 0));
    vecs[17] = mk(0, 0, 0, 0, 0, 0, mk_e(32'h4, 32'h00010203, 32'h0, 32'h4, 1, 0));
    vecs[18] = mk(0, 0, 1, 32'h06, 0, 0, mk_e(32'h6, 32'h0, 32'h0, 32'h4, 0, 0));
    if (TRAP) begin
      vecs[19] = mk(0, 0, 0, 0, 0, 0, mk_e(32'h80, 32'h0, 32'h0, 32'h4, 0, 1));
      vecs[20] = mk(0, 0, 0, 0, 0, 0, mk_e(32'h84, 32'h80818283, 32'h80, 32'h84, 1, 0));
    end else begin
      vecs[19] = mk(0, 0, 0, 0, 0, 0, mk_e(32'hA, 32'h06070809, 32'h6, 32'hA, 1, 0));
      vecs[20] = mk(0, 0, 0, 0, 0, 0, mk_e(32'hE, 32'h0A0B0C0D, 32'hA, 32'hE, 1, 0));
    end
    vecs[21] = mk(0, 0, 0, 0, 1, 32'h20, mk_e(32'h20, 32'h0, hp, hp4, 0, 0));
    vecs[22] = mk(0, 0, 0, 0, 1, 32'h30, mk_e(32'h30, 32'h0, hp, hp4, 0, 0));
    vecs[23] = mk(0, 1, 0, 0, 0, 0, mk_e(32'h30, 32'h0, hp, hp4, 0, 0));
    vecs[24] = mk(0, 0, 0, 0, 0, 0, mk_e(32'h34, 32'h30313233, 32'h30, 32'h34, 1, 0));

    for (int i = 0; i < 25; i++) apply(vecs[i], i);

    // Free-running sequential fetch from 0x34 with expectations from the memory model.
    pc = 32'h34;
    for (int k = 0; k < 6; k++) begin
      apply(mk(0, 0, 0, 0, 0, 0,
               mk_e(pc + 32'd4, mem_word(pc), pc, pc + 32'd4, 1, 0)), 25 + k);
      pc = pc + 32'd4;
    end

    // A one-cycle redirect pulse followed by a stall keeps the bubble in place.
    apply(mk(0, 0, 1, 32'h100, 0, 0, mk_e(32'h100, 32'h0, pc - 32'd4, pc, 0, 0)), 31);
    apply(mk(0, 1, 0, 0, 0, 0, mk_e(32'h100, 32'h0, pc - 32'd4, pc, 0, 0)), 32);
    apply(mk(0, 0, 0, 0, 0, 0, mk_e(32'h104, 32'h00010203, 32'h100, 32'h104, 1, 0)), 33);

    if (sb.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d entries left, expected 0", sb.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/if_fetch_stage.md
Name: if_fetch_stage

Overview:
- Instruction-fetch stage of the MIPS pipeline; sits directly upstream of the instruction memory.
- Owns the program counter and drives the byte address to instruction memory (`im_adress`).
- Takes back the combinational 32-bit big-endian instruction word (`im_instruction`).
- Registers that word, its PC and PC+4 into the IF/ID pipeline register consumed by decode.
- Supports stall, branch/jump redirect and bubble insertion.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- PC_STEP, 4, byte increment per sequential fetch.
- NOP_WORD, 32'h0000_0000, instruction value placed in IF/ID for a bubble.
- TRAP_VECTOR, 32'h0000_0080, redirect target for a misaligned fetch (used only with the optional feature).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- stall  input  1  hazard stall from decode: hold PC and IF/ID.
- branch_en  input  1  taken branch resolved this cycle.
- branch_target  input  32  branch destination byte address.
- jump_en  input  1  jump resolved this cycle.
- jump_target  input  32  jump destination byte address.
- im_adress  output  32  byte address to instruction memory; equals current PC.
- im_instruction  input  32  instruction word returned combinationally by instruction memory.
- ifid_instr  output  32  registered instruction to decode.
- ifid_pc  output  32  registered PC of that instruction.
- ifid_pc_plus4  output  32  registered PC+PC_STEP.
- ifid_valid  output  1  1 = IF/ID holds a real instruction; 0 = bubble.
- fetch_fault  output  1  misaligned-fetch flag (constant 0 when the feature is compiled out).

Behaviour:
- Reset: one clock is enough, and reset has priority over every other input.
  - PC <= RESET_PC.
  - ifid_instr <= NOP_WORD, ifid_pc <= 0, ifid_pc_plus4 <= 0.
  - ifid_valid <= 0, fetch_fault <= 0.
- im_adress = PC, combinational. Fetch latency: the instruction at PC appears on the ifid_* outputs one clock after PC is presented.
- Next-PC priority, evaluated each rising edge when rst=0:
  1. jump_en=1: PC <= jump_target. IF/ID <= bubble (ifid_instr=NOP_WORD, ifid_valid=0, ifid_pc/ifid_pc_plus4 hold their previous values).
  2. branch_en=1 (jump_en=0): PC <= branch_target. IF/ID <= bubble.
  3. stall=1 (no redirect): PC and all ifid_* hold their values.
  4. Otherwise: PC <= PC+PC_STEP. IF/ID <= {im_instruction, PC, PC+PC_STEP}, ifid_valid=1.
- Redirect overrides stall. If jump_en and branch_en are asserted in the same cycle, the jump wins and branch_target is ignored.
- Arithmetic: PC+PC_STEP is 32-bit, modulo 2^32. 32'hFFFF_FFFC+4 wraps to 0 with no flag.
- Redirect targets are loaded unchanged; alignment is not checked unless the feature is enabled.
- Internal state: a 2-state FSM.
  - RUN: normal fetch.
  - REFILL: entered for exactly one cycle after a redirect, i.e. the cycle the new target is fetched.
  - In REFILL, a new redirect is still honoured and a stall still holds. The state serves only for visibility/assertions and never changes the outputs beyond the rules above.
  - rst forces RUN.
- Reset released mid-stall: first cycle after rst deasserts fetches RESET_PC unless stall=1.

Optional Feature:
- Macro: IF_MISALIGN_TRAP_EN.
- Defined:
  - When PC[1:0]!=0 at a normal advance, the instruction is not captured.
  - IF/ID <= bubble, fetch_fault <= 1 for one cycle, PC <= TRAP_VECTOR.
  - This has lower priority than jump/branch and higher priority than stall.
- Undefined:
  - fetch_fault is tied to 0.
  - PC[1:0] is ignored and the misaligned word from memory is captured as-is.

Test Plan:
- Reset then free-run with memory bytes 00..1F = 0x00..0x1F: cycle 1 ifid_instr=0x00010203, ifid_pc=0, ifid_pc_plus4=4, ifid_valid=1; cycle 2 ifid_instr=0x04050607, ifid_pc=4.
- Assert stall for 3 cycles at PC=8: im_adress stays 8, ifid_* frozen at pc=4; release → next ifid_pc=8, ifid_instr=0x08090A0B.
- branch_en=1, branch_target=0x14 with stall=1 simultaneously: next cycle PC=0x14, ifid_valid=0; following cycle ifid_instr=0x14151617, ifid_valid=1.
- jump_en=1 (target 0x0C) and branch_en=1 (target 0x18) together → PC=0x0C, one bubble, then ifid_pc=0x0C.
- rst asserted mid-run at PC=0x10: next cycle PC=RESET_PC, ifid_valid=0, ifid_instr=NOP_WORD. Separately, force PC=0xFFFF_FFFC via jump → next sequential PC=0.
- With IF_MISALIGN_TRAP_EN: jump to 0x06 → following cycle fetch_fault=1, ifid_valid=0, PC=0x80. Without the macro: same jump → ifid_instr=0x06070809, fetch_fault=0.
